// File: rtl/tff_seq_pkg.sv
// Shared types and constants for the T flip-flop bank sequencer.
package tff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: q flips on each rising edge where t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic nq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign nq = ~q;

endmodule

// File: rtl/tff_bank_sequencer.sv
// Drives the toggle inputs of a T flip-flop bank so it acts as a loadable up/down counter
// that runs to a programmable limit under a start/done handshake.
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  seq_state_t       state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] nq;
  logic             carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (count[i]),
      .nq  (nq[i])
    );
  end

  assign tc   = (count == limit);
  assign busy = busy_q;
  assign done = done_q;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down): a ripple carry/borrow chain.
  always_comb begin
    t     = '0;
    carry = 1'b1;
    case (state_q)
      IDLE: begin
        if (load) begin
          t = count ^ load_val;
        end
      end
      RUN: begin
        if (!stop && !tc) begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            t[i]  = carry;
            carry = carry & ((dir == DIR_UP) ? count[i] : nq[i]);
          end
        end
      end
      default: begin
        t = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Load takes priority; a simultaneous start is dropped.
          if (!load && start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tc) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer: reset, up/down runs, wraps, priority, abort, zero-length.
module tb_tff_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;

  int tests = 0;
  int fails = 0;

  tff_bank_sequencer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks count, busy and done together after an edge.
  task automatic chk3(input string tag, input logic [3:0] c, input logic b, input logic d);
    check({tag, ".count"}, {28'd0, count}, {28'd0, c});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    load = 1'b0; load_val = 4'd0; limit = 4'd0;
    tick(); tick();
    chk3("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset mid-run
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    chk3("rm_load", 4'd5, 1'b0, 1'b0);
    limit = 4'd12; dir = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk3("rm_start", 4'd5, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk3("rm_3cnt", 4'd8, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk3("rm_rst", 4'd0, 1'b0, 1'b0);
    tick();
    chk3("rm_after", 4'd0, 1'b0, 1'b0);

    // Up run 3 -> 6
    load = 1'b1; load_val = 4'd3; tick(); load = 1'b0;
    limit = 4'd6; start = 1'b1; tick(); start = 1'b0;
    chk3("up_k", 4'd3, 1'b1, 1'b0);
    tick(); chk3("up_4", 4'd4, 1'b1, 1'b0);
    tick(); chk3("up_5", 4'd5, 1'b1, 1'b0);
    tick(); chk3("up_6", 4'd6, 1'b1, 1'b0);
    check("up_tc", {31'd0, tc}, 32'd1);
    tick(); chk3("up_done", 4'd6, 1'b0, 1'b1);
    tick(); chk3("up_idle", 4'd6, 1'b0, 1'b0);

    // Down wrap 1 -> 0 -> 15 -> 14
    load = 1'b1; load_val = 4'd1; tick(); load = 1'b0;
    limit = 4'd14; dir = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk3("dn_k", 4'd1, 1'b1, 1'b0);
    tick(); chk3("dn_0", 4'd0, 1'b1, 1'b0);
    tick(); chk3("dn_15", 4'd15, 1'b1, 1'b0);
    tick(); chk3("dn_14", 4'd14, 1'b1, 1'b0);
    tick(); chk3("dn_done", 4'd14, 1'b0, 1'b1);
    tick(); chk3("dn_idle", 4'd14, 1'b0, 1'b0);

    // Up wrap 15 -> 0 -> 1
    load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
    limit = 4'd1; dir = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk3("uw_k", 4'd15, 1'b1, 1'b0);
    tick(); chk3("uw_0", 4'd0, 1'b1, 1'b0);
    tick(); chk3("uw_1", 4'd1, 1'b1, 1'b0);
    tick(); chk3("uw_done", 4'd1, 1'b0, 1'b1);
    tick(); chk3("uw_idle", 4'd1, 1'b0, 1'b0);

    // Load beats start
    load = 1'b1; load_val = 4'd9; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
    chk3("pri_load", 4'd9, 1'b0, 1'b0);
    tick(); chk3("pri_idle", 4'd9, 1'b0, 1'b0);

    // Load ignored during RUN, then stop in 2nd RUN cycle
    limit = 4'd12; start = 1'b1; tick(); start = 1'b0;
    chk3("ign_k", 4'd9, 1'b1, 1'b0);
    load = 1'b1; load_val = 4'd2; tick(); load = 1'b0;
    chk3("ign_load", 4'd10, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk3("stop", 4'd10, 1'b0, 1'b0);
    tick(); chk3("stop_idle", 4'd10, 1'b0, 1'b0);

    // Zero-length run at 7; start held in DONE is ignored
    load = 1'b1; load_val = 4'd7; tick(); load = 1'b0;
    limit = 4'd7; start = 1'b1; tick(); start = 1'b0;
    chk3("zl_k", 4'd7, 1'b1, 1'b0);
    check("zl_tc", {31'd0, tc}, 32'd1);
    tick(); chk3("zl_done", 4'd7, 1'b0, 1'b1);
    start = 1'b1; tick();
    chk3("zl_dstart", 4'd7, 1'b0, 1'b0);
    tick(); start = 1'b0;
    chk3("zl_restart", 4'd7, 1'b1, 1'b0);
    tick(); chk3("zl_done2", 4'd7, 1'b0, 1'b1);
    tick(); chk3("zl_idle", 4'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tff_bank_sequencer.md
# tff_bank_sequencer

Synchronous controller for a bank of `WIDTH` T flip-flops. It computes each cycle's per-bit toggle vector so the bank behaves as a loadable up/down counter. The counter runs from its current value to a programmable limit under a start/done handshake. It sits between control logic and the T flip-flop datapath and is the only writer of the toggle inputs.

## Interface
Parameters:
- `WIDTH`, 4, number of T flip-flop cells in the bank (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  abort a run; sampled only in RUN.
- `dir`  in  1  0 = count up, 1 = count down; sampled every RUN cycle.
- `load`  in  1  load `load_val` into the bank; sampled only in IDLE.
- `load_val`  in  WIDTH  value to load.
- `limit`  in  WIDTH  terminal value for a run; sampled every RUN cycle.
- `count`  out  WIDTH  bank Q outputs.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `tc`  out  1  combinational `count == limit`.

## Operation
- Reset: `count`=0, state=IDLE, `busy`=0, `done`=0. `rst` overrides every other input. Reset mid-run aborts immediately, with no `done`.
- The bank is WIDTH T cells. The sequencer drives only the toggle vector `t[WIDTH-1:0]` and never writes Q directly.
- FSM states are IDLE, RUN and DONE.
  - IDLE:
    - `load`=1: t = `count ^ load_val`, so `count` = `load_val` after the edge. State stays IDLE.
    - Otherwise `start`=1: t = 0, next state RUN.
    - Otherwise t = 0.
    - `load` and `start` asserted together: load wins and start is dropped.
  - RUN:
    - `stop`=1: t = 0, next state IDLE, `count` held, no `done`.
    - Otherwise `tc`=1: t = 0, next state DONE.
    - Otherwise, up (`dir`=0): t[0]=1 and t[i] = AND of count[i-1:0].
    - Otherwise, down (`dir`=1): t[0]=1 and t[i] = AND of ~count[i-1:0].
    - `load` and `start` are ignored in RUN.
  - DONE: t = 0, next state IDLE unconditionally. `start` is ignored in this cycle.
- Arithmetic is modulo 2^WIDTH. Up from all-ones wraps to 0 and down from 0 wraps to all-ones; a wrap alone does not end the run.
- `limit` or `dir` changing mid-run takes effect on the next RUN evaluation.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k, and the first `count` change is after edge k+1.
- Run length is N = (limit − count₀) mod 2^W for up and (count₀ − limit) mod 2^W for down. With constant inputs, `count` reaches `limit` after edge k+N.
- DONE is entered at edge k+N+1: `busy`=0 and `done`=1 for exactly one cycle. IDLE follows at edge k+N+2.
- `start` with `count == limit` already: RUN lasts one cycle with no toggle, then DONE.
- `load` takes effect one edge after it is sampled, with `busy`=0 throughout.
- The earliest new `start` is sampled in the first IDLE cycle after DONE.

## Structure
- Package `tff_seq_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE};
  - direction constants `DIR_UP`=0 and `DIR_DOWN`=1.
- Sub-module `tff_cell` (ports: `clk`, `rst`, `t`, `q`, `nq`): one T flip-flop with synchronous active-high reset to q=0. Instantiate it WIDTH times in a generate loop.
- The toggle-vector logic and the FSM are in the top module, with no other hierarchy.

## Test plan
- Reset mid-run:
  - Setup: WIDTH=4, load 5, start up with limit 12, assert `rst` after 3 counts.
  - Required: next cycle `count`=0, `busy`=0, state IDLE, no `done` pulse.
- Up run:
  - Setup: load 3, `limit`=6, `dir`=0, pulse `start`.
  - Required: `count` steps 4, 5, 6 on successive edges; `busy` high 4 cycles; `done` high exactly 1 cycle, one edge after `count` reaches 6.
- Down wrap:
  - Setup: load 1, `limit`=14, `dir`=1, start.
  - Required: `count` steps 0, 15, 14, then `done`.
- Up wrap:
  - Setup: load 15, `limit`=1, `dir`=0.
  - Required: `count` steps 0, 1, then `done`.
- Priority and ignored inputs:
  - Setup 1: in IDLE, assert `load` (`load_val`=9) and `start` together.
  - Required 1: `count`=9, state stays IDLE.
  - Setup 2: during RUN, pulse `load`.
  - Required 2: no effect.
- Abort and zero-length run:
  - Setup 1: `stop` in the 2nd RUN cycle.
  - Required 1: IDLE with `count` held, `done` never asserted.
  - Setup 2: `start` with `count`=`limit`=7.
  - Required 2: one `busy` cycle, then `done`, `count` stays 7.
